// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF response controller.
// Holds the FSM state encoding, default timing parameters and challenge arithmetic.
package puf_pkg;

  localparam int unsigned CHAL_W = 3;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned TMR_W  = 16;

  localparam int unsigned DEF_N_BITS        = 8;
  localparam int unsigned DEF_MEAS_CYCLES   = 1024;
  localparam int unsigned DEF_SETTLE_CYCLES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_MEASURE,
    ST_HOLD,
    ST_CAPTURE,
    ST_DONE
  } puf_state_e;

  // Challenge for bit idx of a run; the 3-bit sum wraps from 7 back to 0.
  function automatic logic [CHAL_W-1:0] chal_of(input logic [CHAL_W-1:0] base,
                                                input logic [IDX_W-1:0]  idx);
    logic [CHAL_W-1:0] sum;
    sum = base + CHAL_W'(idx);
    return sum;
  endfunction

endpackage

// File: rtl/puf_window_timer.sv
// Loadable down-counter timing the oscillator window and the settle interval.
// done_c is high while the count sits at zero, i.e. during the last cycle of a window.
module puf_window_timer
  import puf_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             done_c
);

  logic [TMR_W-1:0] count_q;
  logic [TMR_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_c = (count_q == '0);

endmodule

// File: rtl/puf_response_ctrl.sv
// Sequences a 1-bit PUF cell through clear/measure/settle/capture per challenge
// and assembles an N_BITS response with a valid/ready handoff.
module puf_response_ctrl
  import puf_pkg::*;
#(
  parameter int unsigned N_BITS        = DEF_N_BITS,
  parameter int unsigned MEAS_CYCLES   = DEF_MEAS_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CHAL_W-1:0] chal_base,
  input  logic              abort,
  input  logic              puf_bit,
  output logic              osc_en,
  output logic [CHAL_W-1:0] chal,
  output logic              cnt_clr,
  output logic              busy,
  output logic [N_BITS-1:0] resp,
  output logic              resp_valid,
  input  logic              resp_ready
);

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_BITS - 1);
  localparam logic [TMR_W-1:0] MEAS_LOAD   = TMR_W'(MEAS_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);

  puf_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CHAL_W-1:0] base_q, base_d;
  logic [N_BITS-1:0] resp_q, resp_d;
  logic              osc_en_q, osc_en_d;
  logic              cnt_clr_q, cnt_clr_d;
  logic [CHAL_W-1:0] chal_q, chal_d;
  logic              busy_q, busy_d;
  logic              resp_valid_q, resp_valid_d;

  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_done_c;

  puf_window_timer u_timer (
    .clk      (clk),
    .rst_n    (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done_c   (tmr_done_c)
  );

  // Next state; the timer is reloaded on the edge entering MEASURE and HOLD.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    base_d   = base_q;
    resp_d   = resp_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      resp_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            state_d = ST_CLEAR;
            base_d  = chal_base;
            idx_d   = '0;
            resp_d  = '0;
          end
        end
        ST_CLEAR: begin
          state_d  = ST_MEASURE;
          tmr_load = 1'b1;
          tmr_val  = MEAS_LOAD;
        end
        ST_MEASURE: begin
          if (tmr_done_c) begin
            state_d  = ST_HOLD;
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LOAD;
          end
        end
        ST_HOLD: begin
          if (tmr_done_c) begin
            state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          for (int unsigned i = 0; i < N_BITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
              resp_d[i] = puf_bit;
            end
          end
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CLEAR;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered copies track the state register.
  always_comb begin
    osc_en_d     = (state_d == ST_MEASURE);
    cnt_clr_d    = (state_d == ST_CLEAR);
    busy_d       = (state_d != ST_IDLE);
    resp_valid_d = (state_d == ST_DONE);
    chal_d       = (state_d == ST_IDLE) ? '0 : chal_of(base_d, idx_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      base_q       <= '0;
      resp_q       <= '0;
      osc_en_q     <= 1'b0;
      cnt_clr_q    <= 1'b0;
      chal_q       <= '0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      base_q       <= base_d;
      resp_q       <= resp_d;
      osc_en_q     <= osc_en_d;
      cnt_clr_q    <= cnt_clr_d;
      chal_q       <= chal_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign osc_en     = osc_en_q;
  assign cnt_clr    = cnt_clr_q;
  assign chal       = chal_q;
  assign busy       = busy_q;
  assign resp       = resp_q;
  assign resp_valid = resp_valid_q;

endmodule

// File: doc/puf_response_ctrl.md
PUF_RESPONSE_CTRL -- requirements
Module: puf_response_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
  N_BITS  8  response bits per run, 1..8
  MEAS_CYCLES  1024  oscillator-enable window in clk cycles, 1..65535
  SETTLE_CYCLES  4  post-window quiet cycles before sampling, 1..255
REQ-002 Ports SHALL be, one per line:
  clk  input  1  single clock, rising edge
  rst  input  1  asynchronous active-low reset
  start  input  1  run request, sampled only in IDLE
  chal_base  input  3  first challenge of the run
  abort  input  1  cancel the current run
  puf_bit  input  1  comparator result from the 1-bit PUF cell
  osc_en  output  1  ring-oscillator enable to the PUF cell
  chal  output  3  challenge to the PUF cell
  cnt_clr  output  1  active-high counter clear to the PUF cell
  busy  output  1  run in progress (not IDLE)
  resp  output  N_BITS  assembled response
  resp_valid  output  1  response available
  resp_ready  input  1  consumer accepts the response

Function
REQ-003 The FSM SHALL have states IDLE, CLEAR, MEASURE, HOLD, CAPTURE and DONE.
REQ-004 IDLE with start=1 and abort=0 SHALL latch chal_base, set idx=0 and go to CLEAR; start outside IDLE SHALL be ignored.
REQ-005 CLEAR SHALL last exactly 1 cycle, with cnt_clr=1 and osc_en=0.
REQ-006 MEASURE SHALL last exactly MEAS_CYCLES cycles with osc_en=1; osc_en SHALL be 0 in every other state.
REQ-007 HOLD SHALL last exactly SETTLE_CYCLES cycles with osc_en=0 and cnt_clr=0.
REQ-008 CAPTURE SHALL last 1 cycle and write resp[idx]=puf_bit; if idx==N_BITS-1 it SHALL go to DONE, otherwise to CLEAR with idx+1.
REQ-009 chal SHALL equal (latched chal_base + idx) mod 8 in every non-IDLE state and SHALL be stable from CLEAR through CAPTURE of each bit; the sum SHALL wrap from 7 to 0.
REQ-010 Each bit SHALL take MEAS_CYCLES+SETTLE_CYCLES+2 cycles; resp_valid SHALL rise exactly N_BITS*(MEAS_CYCLES+SETTLE_CYCLES+2) cycles after the start-accept edge.
REQ-011 DONE SHALL hold resp_valid=1 and resp stable until resp_valid and resp_ready are both 1 on an edge, then return to IDLE; resp_ready outside DONE SHALL be ignored.
REQ-012 resp bits not yet written in the current run SHALL read 0; resp SHALL be cleared on start acceptance.
REQ-013 abort=1 in any state other than IDLE SHALL, on the next edge, force IDLE with osc_en=0, resp_valid=0 and resp=0; abort has priority over start and resp_ready.
REQ-014 busy SHALL be 1 exactly when the state is not IDLE, DONE included.
REQ-015 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-016 rst=0 SHALL asynchronously force IDLE, idx=0, osc_en=0, cnt_clr=0, chal=0, busy=0, resp=0 and resp_valid=0.
REQ-017 Reset asserted mid-run SHALL discard the partial response; after release, the first run SHALL behave identically to a run from power-up.

Structure
REQ-018 The state enum, the default parameter values and the challenge width (3) SHALL live in the shared package puf_pkg.
REQ-019 The window timing SHALL use one sub-module, puf_window_timer, a loadable 16-bit down-counter with a done flag, shared by MEASURE and HOLD.

Verification
(Bench parameters: N_BITS=4, MEAS_CYCLES=8, SETTLE_CYCLES=2.)
REQ-020 start with chal_base=3 and a puf_bit model returning 1,0,1,1 -> chal sequence 3,4,5,6; resp=4'b1101; resp_valid rises 48 cycles after accept.
REQ-021 start with chal_base=6 -> chal sequence 6,7,0,1, i.e. wrap-around.
REQ-022 Per bit -> cnt_clr high for exactly 1 cycle, osc_en high for exactly 8 cycles, and 2 quiet cycles before CAPTURE.
REQ-023 resp_ready held low for 20 cycles in DONE -> resp and resp_valid stable throughout; start pulses during the run and during DONE are ignored.
REQ-024 abort during MEASURE of bit 2 -> next cycle IDLE, osc_en=0, resp=0; a fresh start then completes normally.
REQ-025 rst pulsed low mid-HOLD -> all outputs 0 immediately without waiting for a clock edge; after release, a run completes in 48 cycles.
